// File: rtl/keypad_grid_writer.sv
// Scans a 4x4 active-low keypad, debounces one key at a time and writes
// X/O moves into a 3x3 grid. Optional single-level undo via KEYPAD_UNDO_EN.
module keypad_grid_writer #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] keypadCol,
    output logic [3:0] keypadRow,
    input  logic       game_over,
    output logic [1:0] a1,
    output logic [1:0] a2,
    output logic [1:0] a3,
    output logic [1:0] a4,
    output logic [1:0] a5,
    output logic [1:0] a6,
    output logic [1:0] a7,
    output logic [1:0] a8,
    output logic [1:0] a9,
    output logic       turn,
    output logic       move_valid,
    output logic       move_reject
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_ACT      = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         col_s1_q, col_s2_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DB_W-1:0]    db_q, db_d;
    logic [1:0]         row_q, row_d;
    logic [3:0]         row_drive_q, row_drive_d;
    logic [1:0]         key_r_q, key_r_d;
    logic [1:0]         key_c_q, key_c_d;
    logic [3:0]         pat_q, pat_d;
    logic [8:0][1:0]    cells_q, cells_d;
    logic               turn_q, turn_d;
    logic               valid_q, valid_d;
    logic               reject_q, reject_d;
`ifdef KEYPAD_UNDO_EN
    logic               hist_vld_q, hist_vld_d;
    logic [3:0]         hist_idx_q, hist_idx_d;
`endif

    logic               one_low_c;
    logic [1:0]         col_idx_c;
    logic [3:0]         cell_idx_c;

    // Exactly-one-column-low detection on the synchronized columns
    always_comb begin
        one_low_c = 1'b0;
        col_idx_c = 2'd0;
        case (col_s2_q)
            4'b1110: begin one_low_c = 1'b1; col_idx_c = 2'd0; end
            4'b1101: begin one_low_c = 1'b1; col_idx_c = 2'd1; end
            4'b1011: begin one_low_c = 1'b1; col_idx_c = 2'd2; end
            4'b0111: begin one_low_c = 1'b1; col_idx_c = 2'd3; end
            default: begin one_low_c = 1'b0; col_idx_c = 2'd0; end
        endcase
    end

    assign cell_idx_c = 4'(key_r_q) * 4'd3 + 4'(key_c_q);

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        db_d     = db_q;
        row_d    = row_q;
        key_r_d  = key_r_q;
        key_c_d  = key_c_q;
        pat_d    = pat_q;
        cells_d  = cells_q;
        turn_d   = turn_q;
        valid_d  = 1'b0;
        reject_d = 1'b0;
`ifdef KEYPAD_UNDO_EN
        hist_vld_d = hist_vld_q;
        hist_idx_d = hist_idx_q;
`endif
        case (state_q)
            S_SCAN: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (one_low_c) begin
                        key_r_d = row_q;
                        key_c_d = col_idx_c;
                        pat_d   = col_s2_q;
                        db_d    = '0;
                        state_d = S_DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_DEBOUNCE: begin
                if (col_s2_q == pat_q) begin
                    if (db_q == DB_LAST) begin
                        db_d    = '0;
                        state_d = S_ACT;
                    end else begin
                        db_d = db_q + DB_W'(1);
                    end
                end else begin
                    db_d    = '0;
                    state_d = S_SCAN;
                end
            end
            S_ACT: begin
                db_d    = '0;
                state_d = S_RELEASE;
                if (key_r_q != 2'd3 && key_c_q != 2'd3) begin
                    if (game_over || cells_q[cell_idx_c] != 2'b00) begin
                        reject_d = 1'b1;
                    end else begin
                        cells_d[cell_idx_c] = turn_q ? 2'b10 : 2'b01;
                        turn_d  = ~turn_q;
                        valid_d = 1'b1;
`ifdef KEYPAD_UNDO_EN
                        hist_vld_d = 1'b1;
                        hist_idx_d = cell_idx_c;
`endif
                    end
                end else if (key_r_q == 2'd3 && key_c_q == 2'd0) begin
                    cells_d = '0;
                    turn_d  = 1'b0;
`ifdef KEYPAD_UNDO_EN
                    hist_vld_d = 1'b0;
`endif
                end
`ifdef KEYPAD_UNDO_EN
                else if (key_r_q == 2'd3 && key_c_q == 2'd2) begin
                    if (game_over || !hist_vld_q) begin
                        reject_d = 1'b1;
                    end else begin
                        cells_d[hist_idx_q] = 2'b00;
                        turn_d     = ~turn_q;
                        valid_d    = 1'b1;
                        hist_vld_d = 1'b0;
                    end
                end
`endif
            end
            S_RELEASE: begin
                if (col_s2_q == 4'b1111) begin
                    if (db_q == DB_LAST) begin
                        db_d    = '0;
                        state_d = S_SCAN;
                    end else begin
                        db_d = db_q + DB_W'(1);
                    end
                end else begin
                    db_d = '0;
                end
            end
            default: begin
                state_d = S_SCAN;
            end
        endcase
        row_drive_d = ~(4'b0001 << row_d);
    end

    // State register, synchronizer and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_SCAN;
            col_s1_q    <= '0;
            col_s2_q    <= '0;
            div_q       <= '0;
            db_q        <= '0;
            row_q       <= 2'd0;
            row_drive_q <= 4'b1110;
            key_r_q     <= 2'd0;
            key_c_q     <= 2'd0;
            pat_q       <= '0;
            cells_q     <= '0;
            turn_q      <= 1'b0;
            valid_q     <= 1'b0;
            reject_q    <= 1'b0;
`ifdef KEYPAD_UNDO_EN
            hist_vld_q  <= 1'b0;
            hist_idx_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            col_s1_q    <= keypadCol;
            col_s2_q    <= col_s1_q;
            div_q       <= div_d;
            db_q        <= db_d;
            row_q       <= row_d;
            row_drive_q <= row_drive_d;
            key_r_q     <= key_r_d;
            key_c_q     <= key_c_d;
            pat_q       <= pat_d;
            cells_q     <= cells_d;
            turn_q      <= turn_d;
            valid_q     <= valid_d;
            reject_q    <= reject_d;
`ifdef KEYPAD_UNDO_EN
            hist_vld_q  <= hist_vld_d;
            hist_idx_q  <= hist_idx_d;
`endif
        end
    end

    assign keypadRow   = row_drive_q;
    assign a1          = cells_q[0];
    assign a2          = cells_q[1];
    assign a3          = cells_q[2];
    assign a4          = cells_q[3];
    assign a5          = cells_q[4];
    assign a6          = cells_q[5];
    assign a7          = cells_q[6];
    assign a8          = cells_q[7];
    assign a9          = cells_q[8];
    assign turn        = turn_q;
    assign move_valid  = valid_q;
    assign move_reject = reject_q;

endmodule

// File: tb/tb_keypad_grid_writer.sv
// Bench for keypad_grid_writer: a physical keypad model drives the columns and
// a cell-array reference model predicts grid, turn and pulses per key press.
module tb_keypad_grid_writer;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] keypadCol;
    logic [3:0] keypadRow;
    logic       game_over;
    logic [1:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
    logic       turn;
    logic       move_valid;
    logic       move_reject;

    int errors = 0;
    int checks = 0;

    logic       key_down;
    logic [1:0] key_r, key_c;
    logic       glitch_en;
    logic [3:0] glitch_val;

    int m_cell[9];
    int m_turn;
    int m_hist;

    keypad_grid_writer #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clock(clock), .reset(reset), .keypadCol(keypadCol), .keypadRow(keypadRow),
        .game_over(game_over),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .a8(a8), .a9(a9),
        .turn(turn), .move_valid(move_valid), .move_reject(move_reject)
    );

    always #5 clock = ~clock;

    // Key matrix: a held key pulls its column low only while its row is driven
    always_comb begin
        keypadCol = 4'hF;
        if (glitch_en)
            keypadCol = glitch_val;
        else if (key_down && keypadRow[key_r] == 1'b0)
            keypadCol = ~(4'b0001 << key_c);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] grid_obs();
        return 32'({a9, a8, a7, a6, a5, a4, a3, a2, a1});
    endfunction

    function automatic logic [31:0] grid_exp();
        logic [31:0] g = '0;
        for (int i = 0; i < 9; i++) g[2*i +: 2] = 2'(m_cell[i]);
        return g;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_cell[i] = 0;
        m_turn = 0;
        m_hist = -1;
    endtask

    task automatic model_key(input int r, input int c, input logic go,
                             output int ev, output int er);
        ev = 0;
        er = 0;
        if (r < 3 && c < 3) begin
            if (go || m_cell[3*r + c] != 0) begin
                er = 1;
            end else begin
                m_cell[3*r + c] = (m_turn == 1) ? 2 : 1;
                m_turn = 1 - m_turn;
                m_hist = 3*r + c;
                ev = 1;
            end
        end else if (r == 3 && c == 0) begin
            model_reset();
        end
`ifdef KEYPAD_UNDO_EN
        else if (r == 3 && c == 2) begin
            if (go || m_hist < 0) begin
                er = 1;
            end else begin
                m_cell[m_hist] = 0;
                m_turn = 1 - m_turn;
                m_hist = -1;
                ev = 1;
            end
        end
`endif
    endtask

    task automatic press(input int r, input int c, input string tag);
        int ev, er, nv, nr;
        model_key(r, c, game_over, ev, er);
        key_r = 2'(r);
        key_c = 2'(c);
        key_down = 1'b1;
        nv = 0;
        nr = 0;
        repeat (40) begin
            @(negedge clock);
            if (move_valid) nv++;
            if (move_reject) nr++;
        end
        key_down = 1'b0;
        repeat (15) begin
            @(negedge clock);
            if (move_valid) nv++;
            if (move_reject) nr++;
        end
        check($sformatf("%s_valid", tag), 32'(nv), 32'(ev));
        check($sformatf("%s_reject", tag), 32'(nr), 32'(er));
        check($sformatf("%s_grid", tag), grid_obs(), grid_exp());
        check($sformatf("%s_turn", tag), 32'(turn), 32'(m_turn));
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s_row", tag), 32'(keypadRow), 32'h0000_000E);
        check($sformatf("%s_grid", tag), grid_obs(), 32'h0);
        check($sformatf("%s_turn", tag), 32'(turn), 32'h0);
        check($sformatf("%s_pulse", tag), 32'({move_valid, move_reject}), 32'h0);
    endtask

    initial begin
        int nv, nr, found;
        logic [3:0] rows_seen;

        reset      = 1'b0;
        key_down   = 1'b0;
        key_r      = 2'd0;
        key_c      = 2'd0;
        glitch_en  = 1'b0;
        glitch_val = 4'hF;
        game_over  = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check_reset_outputs("por");
        reset = 1'b1;

        press(1, 1, "a5_x");
        press(0, 0, "a1_o");
        press(1, 1, "a5_dup");

        // Two-cycle column glitch while row 1 is driven
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (keypadRow == 4'b1101) begin
                found = 1;
                break;
            end
        end
        check("glitch_row_seen", 32'(found), 32'h1);
        nv = 0;
        nr = 0;
        rows_seen = 4'h0;
        glitch_val = 4'b1101;
        glitch_en  = 1'b1;
        repeat (2) begin
            @(negedge clock);
            if (move_valid) nv++;
            if (move_reject) nr++;
        end
        glitch_en = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (move_valid) nv++;
            if (move_reject) nr++;
            rows_seen = rows_seen | ~keypadRow;
        end
        check("glitch_pulses", 32'({nv[15:0], nr[15:0]}), 32'h0);
        check("glitch_grid", grid_obs(), grid_exp());
        check("glitch_turn", 32'(turn), 32'(m_turn));
        check("glitch_scan_resumes", 32'(rows_seen), 32'h0000_000F);

        game_over = 1'b1;
        press(2, 2, "go_a9");
        press(3, 0, "go_clear");
        game_over = 1'b0;

`ifdef KEYPAD_UNDO_EN
        press(0, 2, "a3");
        press(3, 2, "undo");
        press(3, 2, "undo_empty");
`else
        press(3, 2, "undo_off");
`endif
        press(3, 3, "nokey");

        for (int n = 0; n < 60; n++) begin
            game_over = ($urandom_range(0, 5) == 0);
            press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rnd");
        end
        game_over = 1'b0;

        // Reset while a key is mid-debounce, with a populated grid beforehand
        press(3, 0, "pre_clear");
        press(1, 1, "pre_a5");
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        key_r    = 2'd0;
        key_c    = 2'd0;
        key_down = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_db_rst");
        key_down = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        nv = 0;
        nr = 0;
        repeat (40) begin
            @(negedge clock);
            if (move_valid) nv++;
            if (move_reject) nr++;
        end
        check("mid_db_no_pulse", 32'({nv[15:0], nr[15:0]}), 32'h0);
        check("mid_db_grid", grid_obs(), 32'h0);
        press(1, 1, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
